// File: rtl/bus_dma_pkg.sv
// Shared definitions for the single-channel word-copy DMA engine:
// FSM encoding, register offsets, CTRL/STATUS bit positions, MMIO base.
package bus_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_CLR   = 4;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;
  localparam int STAT_IE   = 3;

  localparam logic [31:0] MMIO_BASE = 32'h9d00_0000;

  function automatic logic [31:0] word_align(input logic [31:0] v);
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/bus_dma.sv
// Single-channel DMA: MMIO slave register file plus a RD/WR master FSM
// that copies LEN words from SRC to DST in ascending order.
module bus_dma
  import bus_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  s_a,
  input  logic [31:0] s_d,
  input  logic        s_we,
  output logic [31:0] s_spo,
  output logic [31:0] m_a,
  output logic [31:0] m_d,
  output logic        m_rd,
  output logic        m_we,
  input  logic [31:0] m_spo,
  input  logic        m_ready,
  input  logic        m_err,
  output logic        irq
);

  state_e             state_q, state_d;
  logic [31:0]        src_q, src_d;
  logic [31:0]        dst_q, dst_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [31:0]        buf_q, buf_d;
  logic [31:0]        m_a_q, m_a_d;
  logic               m_rd_q, m_rd_d;
  logic               m_we_q, m_we_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ie_q, ie_d;

  logic               busy;
  logic               ctrl_wr;
  logic               start;
  logic [31:0]        wdat;

  assign busy    = (state_q != ST_IDLE);
  assign wdat    = word_align(s_d);
  assign ctrl_wr = s_we && (s_a == REG_CTRL);
  assign start   = ctrl_wr && s_d[CTRL_START] && !busy;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    buf_d   = buf_q;
    m_a_d   = m_a_q;
    m_rd_d  = m_rd_q;
    m_we_d  = m_we_q;
    done_d  = done_q;
    err_d   = err_q;
    ie_d    = ie_q;

    if (s_we && !busy) begin
      unique case (1'b1)
        (s_a == REG_SRC): src_d = wdat;
        (s_a == REG_DST): dst_d = wdat;
        (s_a == REG_LEN): len_d = wdat[LEN_W-1:0];
        default: ;
      endcase
    end

    // IE and CLR apply even mid-transfer; FSM events below override CLR
    if (ctrl_wr) begin
      ie_d = s_d[CTRL_IE];
      if (s_d[CTRL_CLR]) begin
        done_d = 1'b0;
        err_d  = 1'b0;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          if (len_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RD;
            m_rd_d  = 1'b1;
            m_a_d   = src_q;
          end
        end
      end
      ST_RD: begin
        if (m_err) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          m_rd_d  = 1'b0;
        end else if (m_ready) begin
          state_d = ST_WR;
          buf_d   = m_spo;
          m_rd_d  = 1'b0;
          m_we_d  = 1'b1;
          m_a_d   = dst_q;
        end
      end
      ST_WR: begin
        if (m_err) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          m_we_d  = 1'b0;
        end else if (m_ready) begin
          src_d  = src_q + 32'd4;
          dst_d  = dst_q + 32'd4;
          len_d  = len_q - LEN_W'(1);
          m_we_d = 1'b0;
          if (len_q == LEN_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RD;
            m_rd_d  = 1'b1;
            m_a_d   = src_q + 32'd4;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      buf_q   <= '0;
      m_a_q   <= '0;
      m_rd_q  <= 1'b0;
      m_we_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      m_a_q   <= m_a_d;
      m_rd_q  <= m_rd_d;
      m_we_q  <= m_we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ie_q    <= ie_d;
    end
  end

  always_comb begin
    s_spo = '0;
    unique case (s_a)
      REG_SRC: s_spo = src_q;
      REG_DST: s_spo = dst_q;
      REG_LEN: s_spo = 32'(len_q);
      default: begin
        s_spo[STAT_BUSY] = busy;
        s_spo[STAT_DONE] = done_q;
        s_spo[STAT_ERR]  = err_q;
        s_spo[STAT_IE]   = ie_q;
      end
    endcase
  end

  assign m_a  = m_a_q;
  assign m_d  = buf_q;
  assign m_rd = m_rd_q;
  assign m_we = m_we_q;
  assign irq  = ie_q & (done_q | err_q);

endmodule

// File: tb/tb_bus_dma.sv
// Randomized self-checking bench for bus_dma against a word-array copy model.
// Memory window is 1024 words, indexed by address bits [11:2].
module tb_bus_dma;
  import bus_dma_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  s_a = 2'd0;
  logic [31:0] s_d = '0;
  logic        s_we = 1'b0;
  logic [31:0] s_spo;
  logic [31:0] m_a, m_d, m_spo;
  logic        m_rd, m_we, m_ready, m_err, irq;

  bus_dma #(.LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_spo(s_spo),
    .m_a(m_a), .m_d(m_d), .m_rd(m_rd), .m_we(m_we),
    .m_spo(m_spo), .m_ready(m_ready), .m_err(m_err), .irq(irq)
  );

  always #5 clk = ~clk;

  logic [31:0] mem   [1024];
  logic [31:0] ref_m [1024];
  int  wait_n = 0;
  int  wcnt = 0;
  bit  err_en = 1'b0;

  assign m_spo   = mem[m_a[11:2]];
  assign m_err   = err_en && (m_rd || m_we) && (m_a[31:28] == 4'ha);
  assign m_ready = (wcnt >= wait_n);

  int rd_cnt = 0, wr_cnt = 0, req_cnt = 0, both_cnt = 0, stab_err = 0;
  logic [65:0] prev = '0;
  bit hold = 1'b0;

  always @(posedge clk) begin
    if (hold && ({m_rd, m_we, m_a, m_d} !== prev)) stab_err <= stab_err + 1;
    prev <= {m_rd, m_we, m_a, m_d};
    hold <= (m_rd || m_we) && !m_ready && !m_err;
    if (m_rd || m_we) req_cnt <= req_cnt + 1;
    if (m_rd && m_we) both_cnt <= both_cnt + 1;
    if (m_rd && m_ready && !m_err) rd_cnt <= rd_cnt + 1;
    if (m_we && m_ready && !m_err) begin
      wr_cnt <= wr_cnt + 1;
      mem[m_a[11:2]] <= m_d;
    end
    if (m_rd || m_we) begin
      if (m_ready || m_err) wcnt <= 0;
      else wcnt <= wcnt + 1;
    end
  end

  int pass_cnt = 0;
  int total = 0;

  task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
    s_a = a; s_d = d; s_we = 1'b1;
    @(posedge clk); #1;
    s_we = 1'b0;
  endtask

  task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
    s_a = a;
    #1;
    d = s_spo;
  endtask

  task automatic wait_idle(input int limit, output int cyc);
    cyc = 0;
    s_a = REG_CTRL;
    #1;
    while (s_spo[STAT_BUSY] && cyc < limit) begin
      @(posedge clk); #2;
      cyc++;
    end
    total++;
    if (s_spo[STAT_BUSY]) $display("FAIL wait_idle timeout after %0d cycles", cyc);
    else pass_cnt++;
  endtask

  task automatic prep_mem(input logic [31:0] src, input logic [31:0] dst, input int len);
    int s, d;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 0; i < 1024; i++) ref_m[i] = mem[i];
    s = int'(src[11:2]);
    d = int'(dst[11:2]);
    for (int i = 0; i < len; i++) ref_m[(d + i) % 1024] = ref_m[(s + i) % 1024];
  endtask

  task automatic check_result(input string nm, input logic [31:0] src,
                              input logic [31:0] dst, input int len,
                              input int rd0, input int wr0, input int st0);
    logic [31:0] v;
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_m[i]) bad++;
    total++;
    if (bad != 0) $display("FAIL %s mem: %0d words differ, want 0", nm, bad);
    else pass_cnt++;
    reg_rd(REG_SRC, v);
    total++;
    if (v !== src + 32'(4 * len)) $display("FAIL %s src: got %h want %h", nm, v, src + 32'(4 * len));
    else pass_cnt++;
    reg_rd(REG_DST, v);
    total++;
    if (v !== dst + 32'(4 * len)) $display("FAIL %s dst: got %h want %h", nm, v, dst + 32'(4 * len));
    else pass_cnt++;
    reg_rd(REG_LEN, v);
    total++;
    if (v !== 32'd0) $display("FAIL %s len: got %h want 0", nm, v);
    else pass_cnt++;
    reg_rd(REG_CTRL, v);
    total++;
    if (v !== 32'h2 || irq !== 1'b0) $display("FAIL %s status: got %h irq %b want 2 irq 0", nm, v, irq);
    else pass_cnt++;
    total++;
    if (rd_cnt - rd0 != len || wr_cnt - wr0 != len)
      $display("FAIL %s xfers: rd %0d wr %0d want %0d each", nm, rd_cnt - rd0, wr_cnt - wr0, len);
    else pass_cnt++;
    total++;
    if (stab_err != st0 || both_cnt != 0)
      $display("FAIL %s stable: changes %0d both %0d want 0", nm, stab_err - st0, both_cnt);
    else pass_cnt++;
  endtask

  task automatic run_copy(input string nm, input logic [31:0] src,
                          input logic [31:0] dst, input int len, input int w);
    int rd0, wr0, st0, cyc;
    wait_n = w;
    prep_mem(src, dst, len);
    @(posedge clk); #1;
    rd0 = rd_cnt; wr0 = wr_cnt; st0 = stab_err;
    reg_wr(REG_SRC, src);
    reg_wr(REG_DST, dst);
    reg_wr(REG_LEN, 32'(len));
    reg_wr(REG_CTRL, 32'h1);
    wait_idle(2 * len * (1 + w) + 20, cyc);
    total++;
    if (cyc != 2 * len * (1 + w)) $display("FAIL %s done_time: got %0d want %0d", nm, cyc, 2 * len * (1 + w));
    else pass_cnt++;
    check_result(nm, src, dst, len, rd0, wr0, st0);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({m_rd, m_we, irq} !== 3'b0 || m_a !== '0 || m_d !== '0)
      $display("FAIL reset_outs: rd %b we %b irq %b a %h d %h want 0", m_rd, m_we, irq, m_a, m_d);
    else pass_cnt++;
    for (int r = 0; r < 4; r++) begin
      reg_rd(2'(r), v);
      total++;
      if (v !== '0) $display("FAIL reset_reg%0d: got %h want 0", r, v);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_copy("basic", 32'h1000_0000, 32'h1000_0100, 4, 0);
  endtask

  task automatic test_wait_states();
    run_copy("waits", 32'h1000_0000, 32'h1000_0100, 4, 3);
  endtask

  task automatic test_len_zero();
    logic [31:0] v;
    int rq0;
    wait_n = 0;
    reg_wr(REG_LEN, 32'h0);
    rq0 = req_cnt;
    reg_wr(REG_CTRL, 32'h3);
    reg_rd(REG_CTRL, v);
    total++;
    if (v !== 32'ha || irq !== 1'b1) $display("FAIL len0_done: got %h irq %b want a irq 1", v, irq);
    else pass_cnt++;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (req_cnt != rq0) $display("FAIL len0_traffic: got %0d requests want 0", req_cnt - rq0);
    else pass_cnt++;
    reg_wr(REG_CTRL, 32'h12);
    reg_rd(REG_CTRL, v);
    total++;
    if (v !== 32'h8 || irq !== 1'b0) $display("FAIL len0_clr: got %h irq %b want 8 irq 0", v, irq);
    else pass_cnt++;
    reg_wr(REG_CTRL, 32'h0);
  endtask

  task automatic test_bus_error();
    logic [31:0] v;
    int wr0, cyc;
    wait_n = 0;
    err_en = 1'b1;
    wr0 = wr_cnt;
    reg_wr(REG_SRC, 32'ha000_0000);
    reg_wr(REG_DST, 32'h1000_0000);
    reg_wr(REG_LEN, 32'd4);
    reg_wr(REG_CTRL, 32'h3);
    wait_idle(20, cyc);
    reg_rd(REG_CTRL, v);
    total++;
    if (v !== 32'hc || irq !== 1'b1 || cyc != 1)
      $display("FAIL err_status: got %h irq %b cyc %0d want c irq 1 cyc 1", v, irq, cyc);
    else pass_cnt++;
    total++;
    if (wr_cnt != wr0 || m_rd !== 1'b0 || m_we !== 1'b0)
      $display("FAIL err_nowrite: writes %0d rd %b we %b want 0", wr_cnt - wr0, m_rd, m_we);
    else pass_cnt++;
    reg_rd(REG_SRC, v);
    total++;
    if (v !== 32'ha000_0000) $display("FAIL err_src: got %h want a0000000", v);
    else pass_cnt++;
    reg_rd(REG_LEN, v);
    total++;
    if (v !== 32'd4) $display("FAIL err_len: got %h want 4", v);
    else pass_cnt++;
    reg_wr(REG_CTRL, 32'h12);
    reg_rd(REG_CTRL, v);
    total++;
    if (v !== 32'h8 || irq !== 1'b0) $display("FAIL err_clr: got %h irq %b want 8 irq 0", v, irq);
    else pass_cnt++;
    err_en = 1'b0;
    reg_wr(REG_CTRL, 32'h0);
  endtask

  task automatic test_busy_writes();
    logic [31:0] src, dst, vs, vl;
    int rd0, wr0, st0, cyc;
    src = 32'h1000_0000 + 32'(4 * $urandom_range(0, 400));
    dst = 32'h1000_0000 + 32'(4 * $urandom_range(500, 900));
    wait_n = 1;
    prep_mem(src, dst, 8);
    @(posedge clk); #1;
    rd0 = rd_cnt; wr0 = wr_cnt; st0 = stab_err;
    reg_wr(REG_SRC, src);
    reg_wr(REG_DST, dst);
    reg_wr(REG_LEN, 32'd8);
    reg_wr(REG_CTRL, 32'h1);
    repeat (5) @(posedge clk);
    #1;
    reg_wr(REG_SRC, 32'h0000_0555);
    reg_wr(REG_LEN, 32'd3);
    reg_wr(REG_CTRL, 32'h1);
    reg_rd(REG_SRC, vs);
    reg_rd(REG_LEN, vl);
    total++;
    if (vl == 0 || vl >= 8 || vs - src != 4 * (8 - vl))
      $display("FAIL busy_live: src %h len %0d inconsistent with start %h/8", vs, vl, src);
    else pass_cnt++;
    wait_idle(100, cyc);
    check_result("busy", src, dst, 8, rd0, wr0, st0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int n;
    wait_n = 0;
    prep_mem(32'h1000_0000, 32'h1000_0200, 8);
    reg_wr(REG_SRC, 32'h1000_0000);
    reg_wr(REG_DST, 32'h1000_0200);
    reg_wr(REG_LEN, 32'd8);
    reg_wr(REG_CTRL, 32'h3);
    n = 0;
    while (m_we !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (m_we !== 1'b1) $display("FAIL rst_mid_wr: m_we %b want 1 within 20 cycles", m_we);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    reg_rd(REG_CTRL, v);
    total++;
    if (m_we !== 1'b0 || m_rd !== 1'b0 || v !== '0 || irq !== 1'b0)
      $display("FAIL rst_mid: we %b rd %b status %h irq %b want 0", m_we, m_rd, v, irq);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_copy("after_rst", 32'h1000_0040, 32'h1000_0300, 8, 0);
  endtask

  task automatic test_random();
    logic [31:0] src, dst;
    int si, len, w;
    for (int it = 0; it < 4; it++) begin
      len = 4 * $urandom_range(1, 4);
      w = $urandom_range(0, 2);
      if (it == 0) begin
        src = 32'hffff_fff8;
        dst = 32'h1000_0200;
      end else begin
        si = $urandom_range(16, 900);
        src = 32'h1000_0000 + 32'(4 * si);
        if (it[0]) dst = src + 32'(4 * $urandom_range(0, 24)) - 32'd48;
        else dst = 32'h1000_0000 + 32'(4 * $urandom_range(0, 1000));
      end
      run_copy($sformatf("rand%0d", it), src, dst, len, w);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_len_zero();
    test_bus_error();
    test_busy_writes();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
